// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/controller memory protocol.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IWORD  = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2
  } gnt_kind_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  // Data returned to the requester when the RAM reports ERROR.
  localparam word_t BAD_WORD = 32'hBAD1BAD1;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational CPU picker: first requester found searching upward from the pointer.
module arb_select
  import cpu_types_pkg::*;
#(
  parameter int unsigned NCPUS = 2
) (
  input  logic [NCPUS-1:0]               i_req,
  input  logic [ptr_width(NCPUS)-1:0]    i_ptr,
  output logic [NCPUS-1:0]               o_gnt
);

  localparam int unsigned PW = ptr_width(NCPUS);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NCPUS; k++) begin
      w_idx = PW'((32'(i_ptr) + k) % NCPUS);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises per-CPU instruction/data requests onto one RAM port.
// MEMARB_ROUND_ROBIN_EN selects round-robin CPU arbitration; default is fixed priority.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned NCPUS = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NCPUS-1:0]        iREN,
  input  logic [NCPUS-1:0]        dREN,
  input  logic [NCPUS-1:0]        dWEN,
  input  word_t [NCPUS-1:0]       iaddr,
  input  word_t [NCPUS-1:0]       daddr,
  input  word_t [NCPUS-1:0]       dstore,
  output logic [NCPUS-1:0]        iwait,
  output logic [NCPUS-1:0]        dwait,
  output word_t [NCPUS-1:0]       iload,
  output word_t [NCPUS-1:0]       dload,
  output logic                    ramREN,
  output logic                    ramWEN,
  output word_t                   ramaddr,
  output word_t                   ramstore,
  input  word_t                   ramload,
  input  ramstate_t               ramstate
);

  localparam int unsigned PW = ptr_width(NCPUS);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [PW-1:0] r_gnt_cpu;
  logic [PW-1:0] w_gnt_cpu_nxt;
  gnt_kind_t     r_gnt_kind;
  gnt_kind_t     w_gnt_kind_nxt;

  logic [NCPUS-1:0] w_req;
  logic [NCPUS-1:0] w_gnt_oh;
  logic [PW-1:0]    w_sel_cpu;
  gnt_kind_t        w_sel_kind;
  logic [PW-1:0]    w_ptr;
  logic             w_gnt_req;
  word_t            w_load;

  assign w_req = iREN | dREN | dWEN;

  arb_select #(.NCPUS(NCPUS)) u_arb_select (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt_oh)
  );

`ifdef MEMARB_ROUND_ROBIN_EN
  logic [PW-1:0] r_ptr;
  logic          w_done;

  // A completion is the only time a wait bit goes low.
  assign w_done = ~(&iwait & &dwait);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr <= '0;
    end else if (w_done) begin
      r_ptr <= (r_gnt_cpu == PW'(NCPUS - 1)) ? '0 : r_gnt_cpu + PW'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // One-hot winner to index, then kind priority dWEN > dREN > iREN.
  always_comb begin
    w_sel_cpu = '0;
    for (int unsigned c = 0; c < NCPUS; c++) begin
      if (w_gnt_oh[c]) w_sel_cpu = PW'(c);
    end
    if (dWEN[w_sel_cpu])      w_sel_kind = DWRITE;
    else if (dREN[w_sel_cpu]) w_sel_kind = DREAD;
    else                      w_sel_kind = IWORD;
  end

  always_comb begin
    case (r_gnt_kind)
      IWORD:   w_gnt_req = iREN[r_gnt_cpu];
      DREAD:   w_gnt_req = dREN[r_gnt_cpu];
      DWRITE:  w_gnt_req = dWEN[r_gnt_cpu];
      default: w_gnt_req = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_gnt_cpu  <= '0;
      r_gnt_kind <= IWORD;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_cpu  <= w_gnt_cpu_nxt;
      r_gnt_kind <= w_gnt_kind_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_cpu_nxt  = r_gnt_cpu;
    w_gnt_kind_nxt = r_gnt_kind;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;
    iwait          = '1;
    dwait          = '1;
    iload          = '0;
    dload          = '0;
    w_load         = (ramstate == ACCESS) ? ramload : BAD_WORD;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_state_nxt    = SERVE;
          w_gnt_cpu_nxt  = w_sel_cpu;
          w_gnt_kind_nxt = w_sel_kind;
        end
      end
      SERVE: begin
        ramWEN   = (r_gnt_kind == DWRITE);
        ramREN   = (r_gnt_kind != DWRITE);
        ramaddr  = (r_gnt_kind == IWORD) ? iaddr[r_gnt_cpu] : daddr[r_gnt_cpu];
        ramstore = (r_gnt_kind == DWRITE) ? dstore[r_gnt_cpu] : '0;
        // Dropped request aborts without completing.
        if (!w_gnt_req) begin
          w_state_nxt = IDLE;
        end else if (ramstate == ACCESS || ramstate == ERROR) begin
          w_state_nxt = IDLE;
          if (r_gnt_kind == IWORD) begin
            iwait[r_gnt_cpu] = 1'b0;
            iload[r_gnt_cpu] = w_load;
          end else begin
            dwait[r_gnt_cpu] = 1'b0;
            dload[r_gnt_cpu] = w_load;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (NCPUS = 2).
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned N = 2;
`ifdef MEMARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic [N-1:0]     iREN, dREN, dWEN;
  word_t [N-1:0]    iaddr, daddr, dstore;
  logic [N-1:0]     iwait, dwait;
  word_t [N-1:0]    iload, dload;
  logic             ramREN, ramWEN;
  word_t            ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  int nchecks;
  int nerrors;

  memory_arbiter #(.NCPUS(N)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    step();
    RST = 1'b1;
    iREN = 2'b01;
    step();
    step();
    settle();
    nchecks++; if (iwait !== 2'b11) begin nerrors++; $display("FAIL reset_iwait: got %b want %b", iwait, 2'b11); end
    nchecks++; if (dwait !== 2'b11) begin nerrors++; $display("FAIL reset_dwait: got %b want %b", dwait, 2'b11); end
    nchecks++; if ({ramREN, ramWEN} !== 2'b00) begin nerrors++; $display("FAIL reset_ramen: got %b want 00", {ramREN, ramWEN}); end
    nchecks++; if ((iload | dload) !== '0) begin nerrors++; $display("FAIL reset_loads: got %h/%h want 0", iload, dload); end
    nchecks++; if (ramaddr !== 32'h0) begin nerrors++; $display("FAIL reset_ramaddr: got %h want 0", ramaddr); end
    step();
    RST = 1'b0;
    iREN = 2'b00;
  endtask

  task automatic test_single_fetch();
    step();
    iREN[0] = 1'b1;
    iaddr[0] = 32'h40;
    ramstate = BUSY;
    settle();
    nchecks++; if (ramREN !== 1'b0) begin nerrors++; $display("FAIL fetch_idle_ren: got %b want 0", ramREN); end
    for (int i = 0; i < 2; i++) begin
      step();
      settle();
      nchecks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin nerrors++; $display("FAIL fetch_busy%0d: ren %b addr %h want 1 00000040", i, ramREN, ramaddr); end
      nchecks++; if (iwait[0] !== 1'b1) begin nerrors++; $display("FAIL fetch_busy_wait%0d: got %b want 1", i, iwait[0]); end
    end
    step();
    ramstate = ACCESS;
    ramload = 32'h8C010004;
    settle();
    nchecks++; if (iwait[0] !== 1'b0) begin nerrors++; $display("FAIL fetch_access_wait: got %b want 0", iwait[0]); end
    nchecks++; if (iload[0] !== 32'h8C010004) begin nerrors++; $display("FAIL fetch_iload: got %h want 8c010004", iload[0]); end
    nchecks++; if (iload[1] !== 32'h0) begin nerrors++; $display("FAIL fetch_iload1: got %h want 0", iload[1]); end
    step();
    ramstate = FREE;
    settle();
    nchecks++; if (iwait[0] !== 1'b1 || ramREN !== 1'b0 || iload[0] !== 32'h0) begin nerrors++; $display("FAIL fetch_after: wait %b ren %b load %h want 1 0 0", iwait[0], ramREN, iload[0]); end
    step();
    iREN = 2'b00;
  endtask

  task automatic test_conflict();
    step();
    iREN[0] = 1'b1;
    iaddr[0] = 32'h80;
    dWEN[0] = 1'b1;
    daddr[0] = 32'h100;
    dstore[0] = 32'hDEADBEEF;
    ramstate = ACCESS;
    ramload = 32'h55AA55AA;
    step();
    settle();
    nchecks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin nerrors++; $display("FAIL conflict_wr_en: wen %b ren %b want 1 0", ramWEN, ramREN); end
    nchecks++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin nerrors++; $display("FAIL conflict_wr_bus: addr %h data %h want 00000100 deadbeef", ramaddr, ramstore); end
    nchecks++; if (dwait[0] !== 1'b0 || iwait[0] !== 1'b1) begin nerrors++; $display("FAIL conflict_wr_wait: dwait %b iwait %b want 0 1", dwait[0], iwait[0]); end
    step();
    dWEN = 2'b00;
    settle();
    nchecks++; if ({ramREN, ramWEN} !== 2'b00 || iwait[0] !== 1'b1) begin nerrors++; $display("FAIL conflict_gap: en %b iwait %b want 00 1", {ramREN, ramWEN}, iwait[0]); end
    step();
    settle();
    nchecks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || iwait[0] !== 1'b0) begin nerrors++; $display("FAIL conflict_fetch: ren %b addr %h iwait %b want 1 00000080 0", ramREN, ramaddr, iwait[0]); end
    nchecks++; if (iload[0] !== 32'h55AA55AA) begin nerrors++; $display("FAIL conflict_iload: got %h want 55aa55aa", iload[0]); end
    step();
    iREN = 2'b00;
    ramstate = FREE;
  endtask

  task automatic test_two_cpus();
    int unsigned cpu;
    logic [N-1:0] exp_wait;
    word_t exp_addr;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    dREN = 2'b11;
    daddr[0] = 32'h200;
    daddr[1] = 32'h300;
    ramstate = ACCESS;
    ramload = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      cpu = RR ? (i % 2) : 0;
      exp_wait = ~(2'b01 << cpu);
      exp_addr = (cpu == 1) ? 32'h300 : 32'h200;
      step();
      settle();
      nchecks++; if (ramaddr !== exp_addr || dwait !== exp_wait) begin nerrors++; $display("FAIL two_cpu_grant%0d: addr %h dwait %b want %h %b", i, ramaddr, dwait, exp_addr, exp_wait); end
      nchecks++; if (dload[cpu] !== 32'h12345678) begin nerrors++; $display("FAIL two_cpu_dload%0d: got %h want 12345678", i, dload[cpu]); end
      step();
    end
    dREN = 2'b00;
    ramstate = FREE;
  endtask

  task automatic test_error();
    step();
    dREN[1] = 1'b1;
    daddr[1] = 32'h44;
    ramstate = ERROR;
    step();
    settle();
    nchecks++; if (dwait !== 2'b01) begin nerrors++; $display("FAIL error_dwait: got %b want 01", dwait); end
    nchecks++; if (dload[1] !== 32'hBAD1BAD1 || dload[0] !== 32'h0) begin nerrors++; $display("FAIL error_dload: got %h/%h want bad1bad1/0", dload[1], dload[0]); end
    step();
    settle();
    nchecks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin nerrors++; $display("FAIL error_idle: ren %b dwait %b want 0 11", ramREN, dwait); end
    step();
    dREN = 2'b00;
    ramstate = FREE;
  endtask

  task automatic test_mid_reset();
    step();
    dREN = 2'b01;
    daddr[0] = 32'h500;
    daddr[1] = 32'h600;
    ramstate = ACCESS;
    step();
    step();
    ramstate = BUSY;
    step();
    settle();
    nchecks++; if (ramREN !== 1'b1) begin nerrors++; $display("FAIL midrst_busy: ren %b want 1", ramREN); end
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    dREN = 2'b11;
    ramstate = ACCESS;
    settle();
    nchecks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin nerrors++; $display("FAIL midrst_idle: ren %b dwait %b want 0 11", ramREN, dwait); end
    step();
    settle();
    nchecks++; if (ramaddr !== 32'h500 || dwait !== 2'b10) begin nerrors++; $display("FAIL midrst_ptr: addr %h dwait %b want 00000500 10", ramaddr, dwait); end
    step();
    dREN = 2'b00;
    ramstate = FREE;
  endtask

  task automatic test_abort();
    word_t exp_addr;
    logic [N-1:0] exp_wait;
    step();
    dREN = 2'b10;
    daddr[1] = 32'h700;
    ramstate = BUSY;
    step();
    settle();
    nchecks++; if (ramREN !== 1'b1 || ramaddr !== 32'h700) begin nerrors++; $display("FAIL abort_serve: ren %b addr %h want 1 00000700", ramREN, ramaddr); end
    step();
    dREN = 2'b00;
    step();
    dREN = 2'b11;
    ramstate = ACCESS;
    settle();
    nchecks++; if (ramREN !== 1'b0) begin nerrors++; $display("FAIL abort_idle: ren %b want 0", ramREN); end
    exp_addr = RR ? 32'h700 : 32'h500;
    exp_wait = RR ? 2'b01 : 2'b10;
    step();
    settle();
    nchecks++; if (ramaddr !== exp_addr || dwait !== exp_wait) begin nerrors++; $display("FAIL abort_ptr: addr %h dwait %b want %h %b", ramaddr, dwait, exp_addr, exp_wait); end
    step();
    dREN = 2'b00;
    ramstate = FREE;
  endtask

  initial begin
    nchecks  = 0;
    nerrors  = 0;
    RST      = 1'b0;
    iREN     = '0;
    dREN     = '0;
    dWEN     = '0;
    iaddr    = '0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;
    test_reset();
    test_single_fetch();
    test_conflict();
    test_two_cpus();
    test_error();
    test_mid_reset();
    test_abort();
    step();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
